// File: rtl/dice_roller.sv
// Dice game front end: debounces the roll button and runs two chained 1..6 die counters.
// It also presents the dice sum with a settled flag and keeps a saturating roll count.
module dice_roller #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 16,
    parameter int COUNT_W   = 8
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Btn,
    input  logic               Roll,
    output logic               Rb,
    output logic [2:0]         Die1,
    output logic [2:0]         Die2,
    output logic [3:0]         Sum,
    output logic               Sum_valid,
    output logic [COUNT_W-1:0] Roll_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SETTLED = 2'd2
    } state_t;

    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic [1:0]         sync_r;
    logic               btn_s;
    logic [DB_W-1:0]    db_count_r;
    logic [2:0]         die1_next_s;
    logic [2:0]         die2_next_s;
    state_t             state_r;
    state_t             state_next_s;
    logic               sum_valid_next_s;
    logic [COUNT_W-1:0] roll_count_next_s;

    // A die at 6 wraps to 1; illegal values 0 and 7 also recover to 1.
    function automatic logic [2:0] die_next(input logic [2:0] d);
        if ((d >= 3'd6) || (d == 3'd0)) begin
            return 3'd1;
        end else begin
            return d + 3'd1;
        end
    endfunction

    // Two-flop synchroniser on the raw button.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], Btn};
        end
    end

    assign btn_s = sync_r[1];

    // Debounce: Rb follows btn_s only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            db_count_r <= {DB_W{1'b0}};
            Rb         <= 1'b0;
        end else if (btn_s == Rb) begin
            db_count_r <= {DB_W{1'b0}};
        end else if (db_count_r == DB_LAST) begin
            Rb         <= btn_s;
            db_count_r <= {DB_W{1'b0}};
        end else begin
            db_count_r <= db_count_r + DB_W'(1);
        end
    end

    // Next die values: Die1 advances every rolling edge, Die2 carries when Die1 wraps.
    always_comb begin
        die1_next_s = Die1;
        die2_next_s = Die2;
        if (Roll) begin
            die1_next_s = die_next(Die1);
            if (Die1 == 3'd6) begin
                die2_next_s = die_next(Die2);
            end else if ((Die2 == 3'd0) || (Die2 == 3'd7)) begin
                die2_next_s = 3'd1;
            end else begin
                die2_next_s = Die2;
            end
        end else begin
            die1_next_s = Die1;
            die2_next_s = Die2;
        end
    end

    // Die registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Die1 <= 3'd1;
            Die2 <= 3'd1;
        end else begin
            Die1 <= die1_next_s;
            Die2 <= die2_next_s;
        end
    end

    assign Sum = {1'b0, Die1} + {1'b0, Die2};

    // Roll FSM next state; the settle edge also bumps the saturating roll count.
    always_comb begin
        state_next_s      = state_r;
        sum_valid_next_s  = Sum_valid;
        roll_count_next_s = Roll_count;
        case (state_r)
            IDLE: begin
                sum_valid_next_s = 1'b0;
                if (Roll) begin
                    state_next_s = ROLLING;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ROLLING: begin
                if (Roll) begin
                    state_next_s     = ROLLING;
                    sum_valid_next_s = 1'b0;
                end else begin
                    state_next_s     = SETTLED;
                    sum_valid_next_s = 1'b1;
                    if (Roll_count != COUNT_MAX) begin
                        roll_count_next_s = Roll_count + COUNT_W'(1);
                    end else begin
                        roll_count_next_s = Roll_count;
                    end
                end
            end
            SETTLED: begin
                if (Roll) begin
                    state_next_s     = ROLLING;
                    sum_valid_next_s = 1'b0;
                end else begin
                    state_next_s     = SETTLED;
                    sum_valid_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s     = IDLE;
                sum_valid_next_s = 1'b0;
            end
        endcase
    end

    // FSM state, settled flag and roll counter registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r    <= IDLE;
            Sum_valid  <= 1'b0;
            Roll_count <= {COUNT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            Sum_valid  <= sum_valid_next_s;
            Roll_count <= roll_count_next_s;
        end
    end

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: directed steps plus random traffic against a behavioural model
// (dice as a 0..35 sequence index, debounce as a window of synchronised samples).
module tb_dice_roller;

    localparam int DB = 4;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          Btn = 1'b0;
    logic          Roll = 1'b0;
    logic          Rb;
    logic [2:0]    Die1;
    logic [2:0]    Die2;
    logic [3:0]    Sum;
    logic          Sum_valid;
    logic [CW-1:0] Roll_count;

    int checks = 0;
    int errors = 0;

    // model state
    int n = 0;
    bit m_rolling = 1'b0;
    bit m_sv = 1'b0;
    int m_cnt = 0;
    bit m_rb = 1'b0;
    bit m_sync1 = 1'b0;
    bit m_sync2 = 1'b0;
    bit hist[$];

    dice_roller #(.DB_CYCLES(DB), .DB_W(16), .COUNT_W(CW)) dut (
        .CLK(CLK), .Reset(Reset), .Btn(Btn), .Roll(Roll), .Rb(Rb),
        .Die1(Die1), .Die2(Die2), .Sum(Sum), .Sum_valid(Sum_valid),
        .Roll_count(Roll_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_die1();
        return (n % 6) + 1;
    endfunction

    function automatic int m_die2();
        return (n / 6) + 1;
    endfunction

    // One clock: drive inputs, update model from the sampled values, compare outputs.
    task automatic tick(input bit btn, input bit roll, input bit rst);
        bit all_diff;
        Btn = btn;
        Roll = roll;
        Reset = rst;
        @(posedge CLK);
        if (rst) begin
            n = 0; m_rolling = 0; m_sv = 0; m_cnt = 0; m_rb = 0;
            m_sync1 = 0; m_sync2 = 0; hist.delete();
        end else begin
            hist.push_back(m_sync2);
            if (hist.size() > DB) void'(hist.pop_front());
            all_diff = (hist.size() == DB);
            foreach (hist[i]) if (hist[i] == m_rb) all_diff = 1'b0;
            if (all_diff) m_rb = !m_rb;
            m_sync2 = m_sync1;
            m_sync1 = btn;
            if (roll) n = (n + 1) % 36;
            if (m_rolling && !roll) begin
                m_sv = 1'b1;
                if (m_cnt < CMAX) m_cnt++;
            end
            if (roll) m_sv = 1'b0;
            m_rolling = roll;
        end
        #1;
        check("rb", 32'(Rb), 32'(m_rb));
        check("die1", 32'(Die1), 32'(m_die1()));
        check("die2", 32'(Die2), 32'(m_die2()));
        check("sum", 32'(Sum), 32'(m_die1() + m_die2()));
        check("sum_range", 32'((Sum >= 4'd2) && (Sum <= 4'd12)), 32'd1);
        check("sum_valid", 32'(Sum_valid), 32'(m_sv));
        check("roll_count", 32'(Roll_count), 32'(m_cnt));
    endtask

    initial begin
        int lat;
        bit b;
        bit r;
        // reset for two cycles, then idle
        tick(0, 0, 1);
        tick(0, 0, 1);
        check("reset_sum", 32'(Sum), 32'd2);
        for (int i = 0; i < 20; i++) tick(0, 0, 0);
        check("idle_die1", 32'(Die1), 32'd1);

        // clean press: Rb visible DB+2 edges after the change
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1, 0, 0);
            if (lat == 0 && Rb === 1'b1) lat = i;
        end
        check("rb_latency", 32'(lat), 32'(DB + 2));
        // drop for 2 while pressed: no extra toggle
        tick(0, 0, 0); tick(0, 0, 0);
        for (int i = 0; i < 10; i++) tick(1, 0, 0);
        check("rb_glitch_hold", 32'(Rb), 32'd1);
        for (int i = 0; i < 10; i++) tick(0, 0, 0);
        check("rb_release", 32'(Rb), 32'd0);
        // 3-cycle pulse is filtered
        for (int i = 0; i < 3; i++) tick(1, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 0, 0);
        check("rb_short_pulse", 32'(Rb), 32'd0);

        // roll 7 edges from 1/1
        for (int i = 0; i < 7; i++) tick(0, 1, 0);
        tick(0, 0, 0);
        check("roll7_die1", 32'(Die1), 32'd2);
        check("roll7_die2", 32'(Die2), 32'd2);
        check("roll7_sum", 32'(Sum), 32'd4);
        check("roll7_valid", 32'(Sum_valid), 32'd1);
        check("roll7_count", 32'(Roll_count), 32'd1);

        // full 36-edge cycle returns to the start pair
        tick(1, 0, 1);
        tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        for (int i = 0; i < 36; i++) tick(0, 1, 0);
        tick(0, 0, 0);
        check("cycle36_die1", 32'(Die1), 32'd1);
        check("cycle36_die2", 32'(Die2), 32'd1);

        // 300 single-cycle rolls: counter saturates
        for (int k = 0; k < 300; k++) begin
            tick(0, 1, 0);
            tick(0, 0, 0);
            check("pulse_valid", 32'(Sum_valid), 32'd1);
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick(0, 0, 0);
        end
        check("count_sat", 32'(Roll_count), 32'(CMAX));
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        check("count_hold", 32'(Roll_count), 32'(CMAX));

        // reset mid-roll (Die1=5) and mid-debounce
        for (int i = 0; i < 12 && m_die1() != 2; i++) tick(0, 1, 0);
        for (int i = 0; i < 3; i++) tick(1, 1, 0);
        check("pre_reset_die1", 32'(Die1), 32'd5);
        tick(1, 1, 1);
        check("rst_die1", 32'(Die1), 32'd1);
        check("rst_die2", 32'(Die2), 32'd1);
        check("rst_rb", 32'(Rb), 32'd0);
        check("rst_valid", 32'(Sum_valid), 32'd0);
        check("rst_count", 32'(Roll_count), 32'd0);
        for (int i = 0; i < 8; i++) tick(0, 0, 0);
        check("post_reset_rb", 32'(Rb), 32'd0);

        // random traffic: bouncing button and random roll windows
        b = 0;
        r = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5, 0) == 0) b = !b;
            if ($urandom_range(3, 0) == 0) r = !r;
            tick(b, r, ($urandom_range(199, 0) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
